seven_seg_scan_ctrl: RTL and testbench

Time-multiplexing controller that shares the single BCD-to-seven-segment decoder between NUM_DIGITS display digits of the Whack-a-mole score/timer display. It holds a tear-free copy of the digits and scans one digit per refresh slot. Each slot begins with a guard interval against ghosting. The controller drives the decoder's BCD input and its blanking (rst) input, and drives the per-digit enables directly.

---
 rtl/seg_scan_pkg.sv | 22 ++
 rtl/seg_scan_tick.sv | 45 ++++
 rtl/seven_seg_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_pkg
// Brief    : Shared types and helpers for the seven-segment scan controller.
// Revision : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

  typedef enum logic [0:0] {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } scanState_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Counter/index width; never narrower than one bit.
  function automatic int widthOf(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_tick.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_tick
// Brief    : Per-digit slot counter with last-guard-cycle and slot-end flags.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_tick
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2,
  parameter int CNT_W       = widthOf(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_guardDone,
  output logic             o_slotEnd
);

  localparam logic [CNT_W-1:0] c_cntLast   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] c_guardLast = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0] c_cntOne    = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_slotEnd;

  assign w_slotEnd = i_en && (r_cnt == c_cntLast);

  // Held at zero until enabled so the first running cycle starts slot 0 fresh.
  always_ff @(posedge clk) begin
    if (rst || !i_en || w_slotEnd) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cntOne;
    end
  end

  assign o_cnt       = r_cnt;
  assign o_slotEnd   = w_slotEnd;
  assign o_guardDone = i_en && (r_cnt == c_guardLast);

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_ctrl
// Brief    : Multiplexed BCD display scanner with frame-aligned tear-free load.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 100000,
  parameter int GUARD         = 2,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blank_lz,
  output logic [3:0]              bcd,
  output logic                    dec_blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int CNT_W = widthOf(REFRESH_DIV);
  localparam int IDX_W = widthOf(NUM_DIGITS);

  localparam logic [IDX_W-1:0]      c_idxLast  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]      c_idxOne   = IDX_W'(1);
  localparam logic [CNT_W-1:0]      c_guardCnt = CNT_W'(GUARD);
  localparam logic [NUM_DIGITS-1:0] c_anOff    = {NUM_DIGITS{AN_ACTIVE_LOW}};

  scanState_t              r_state;
  scanState_t              w_stateNext;
  logic                    r_started;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idxNext;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [4*NUM_DIGITS-1:0] w_activeNext;
  logic                    r_pending;
  logic                    w_pendingNext;
  logic                    w_boundary;

  logic [CNT_W-1:0]        w_cnt;
  logic                    w_guardDone;
  logic                    w_slotEnd;

  logic [3:0]              w_dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_lzBlank;
  logic [NUM_DIGITS-1:0]   w_anHot;
  logic [3:0]              w_bcdNext;

  logic [NUM_DIGITS-1:0]   r_an;
  logic [3:0]              r_bcd;
  logic                    r_decBlank;
  logic                    r_frameStart;

  seg_scan_tick #(
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD       (GUARD),
    .CNT_W       (CNT_W)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .i_en        (r_started),
    .o_cnt       (w_cnt),
    .o_guardDone (w_guardDone),
    .o_slotEnd   (w_slotEnd)
  );

  // The first running cycle after reset is itself a frame boundary.
  assign w_boundary = !r_started || (w_slotEnd && (r_idx == c_idxLast));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_GUARD;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin : p_fsm
    w_stateNext = r_state;
    if (!r_started || w_slotEnd) begin
      w_stateNext = ST_GUARD;
    end else begin
      case (r_state)
        ST_GUARD: if (w_guardDone) w_stateNext = ST_DRIVE;
        ST_DRIVE: w_stateNext = ST_DRIVE;
        default:  w_stateNext = ST_GUARD;
      endcase
    end
  end

  always_comb begin : p_idx
    w_idxNext = r_idx;
    if (!r_started) begin
      w_idxNext = '0;
    end else if (w_slotEnd) begin
      w_idxNext = (r_idx == c_idxLast) ? '0 : r_idx + c_idxOne;
    end
  end

  // A load coinciding with the boundary bypasses the shadow entirely.
  always_comb begin : p_load
    w_activeNext  = r_active;
    w_pendingNext = r_pending;
    if (w_boundary) begin
      w_pendingNext = 1'b0;
      if (load) begin
        w_activeNext = digits_in;
      end else if (r_pending) begin
        w_activeNext = r_shadow;
      end
    end else if (load) begin
      w_pendingNext = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign w_dig[g] = w_activeNext[4*g +: 4];
  end

  always_comb begin : p_lz
    logic zeroAbove;
    zeroAbove = 1'b1;
    w_lzBlank = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zeroAbove    = zeroAbove && (w_dig[i] == 4'd0);
      w_lzBlank[i] = blank_lz && zeroAbove;
    end
  end

  assign w_bcdNext = w_dig[w_idxNext];

  always_comb begin : p_anHot
    w_anHot            = '0;
    w_anHot[w_idxNext] = 1'b1;
  end

  // Outputs are registered from next-state values so they line up with cnt/idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_started    <= 1'b0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_active     <= '0;
      r_pending    <= 1'b0;
      r_an         <= c_anOff;
      r_bcd        <= 4'd0;
      r_decBlank   <= 1'b1;
      r_frameStart <= 1'b0;
    end else begin
      r_started    <= 1'b1;
      r_idx        <= w_idxNext;
      r_active     <= w_activeNext;
      r_pending    <= w_pendingNext;
      r_frameStart <= w_boundary;
      r_bcd        <= w_bcdNext;
      if (load) begin
        r_shadow <= digits_in;
      end
      if (w_stateNext == ST_DRIVE) begin
        r_an       <= w_anHot ^ c_anOff;
        r_decBlank <= (w_bcdNext > BCD_MAX) || w_lzBlank[w_idxNext];
      end else begin
        r_an       <= c_anOff;
        r_decBlank <= 1'b1;
      end
    end
  end

  a_stateTracksCnt: assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_DRIVE) == (w_cnt >= c_guardCnt));

  assign an          = r_an;
  assign bcd         = r_bcd;
  assign dec_blank   = r_decBlank;
  assign frame_start = r_frameStart;
  assign pending     = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan_ctrl
// Brief    : Directed and random checks of the scan controller against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int RD    = 8;
  localparam int GD    = 2;
  localparam int FRAME = N * RD;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        load     = 1'b0;
  logic        blankLz  = 1'b0;
  logic [15:0] digitsIn = 16'h0000;

  logic [3:0]  bcd;
  logic        decBlank;
  logic [3:0]  an;
  logic        frameStart;
  logic        pendingO;

  int nChecks = 0;
  int nErrors = 0;

  // Model: mK counts running cycles since reset release (-1 while in reset).
  int          mK       = -1;
  logic [15:0] mShadow  = 16'h0000;
  logic [15:0] mActive  = 16'h0000;
  bit          mPending = 1'b0;
  bit          mLz      = 1'b0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS    (N),
    .REFRESH_DIV   (RD),
    .GUARD         (GD),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .digits_in   (digitsIn),
    .blank_lz    (blankLz),
    .bcd         (bcd),
    .dec_blank   (decBlank),
    .an          (an),
    .frame_start (frameStart),
    .pending     (pendingO)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "time limit");
  end

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h want %0h (t=%0t mK=%0d)", tag, act, exp, $time, mK);
    end
  endtask

  task automatic modelEdge();
    if (rst) begin
      mK       = -1;
      mShadow  = 16'h0000;
      mActive  = 16'h0000;
      mPending = 1'b0;
    end else begin
      mK++;
      if (load) mShadow = digitsIn;
      if (mK % FRAME == 0) begin
        if (load) mActive = digitsIn;
        else if (mPending) mActive = mShadow;
        mPending = 1'b0;
      end else if (load) begin
        mPending = 1'b1;
      end
    end
    mLz = blankLz;
  endtask

  task automatic compareAll();
    int          cnt;
    int          slot;
    logic [3:0]  expAn;
    logic [15:0] upper;
    logic [3:0]  dig;
    bit          expBlank;
    if (mK < 0) begin
      checkVal("rstAn", an, 4'hF);
      checkVal("rstBlank", decBlank, 1);
      checkVal("rstBcd", bcd, 0);
      checkVal("rstFs", frameStart, 0);
      checkVal("rstPend", pendingO, 0);
    end else begin
      cnt  = mK % RD;
      slot = (mK / RD) % N;
      checkVal("fs", frameStart, ((mK % FRAME) == 0) ? 1 : 0);
      checkVal("pend", pendingO, mPending);
      if (cnt < GD) begin
        checkVal("guardAn", an, 4'hF);
        checkVal("guardBlank", decBlank, 1);
      end else begin
        expAn    = 4'b0001 << slot;
        expAn    = ~expAn;
        upper    = mActive >> (4 * slot);
        dig      = upper[3:0];
        expBlank = (dig > 4'd9) || (mLz && slot != 0 && upper == 16'h0000);
        checkVal("driveAn", an, expAn);
        checkVal("bcd", bcd, dig);
        checkVal("driveBlank", decBlank, expBlank);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    compareAll();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic doLoad(input logic [15:0] d);
    load     = 1'b1;
    digitsIn = d;
    cyc();
    load     = 1'b0;
  endtask

  // Advance until the next clock edge lands on frame phase ph.
  task automatic seekPhase(input int ph);
    int budget;
    budget = 0;
    while (((mK + 1) % FRAME) != ph && budget < 2 * FRAME) begin
      cyc();
      budget++;
    end
  endtask

  initial begin
    logic [15:0] d;

    idle(3);
    rst = 1'b0;
    cyc();
    checkVal("relFs0", frameStart, 1);
    checkVal("relAn0", an, 4'hF);
    cyc();
    checkVal("relAn1", an, 4'hF);
    cyc();
    checkVal("relAn2", an, 4'hE);
    idle(8);
    checkVal("relAn10", an, 4'hD);
    idle(22);
    checkVal("relFs32", frameStart, 1);

    // Mid-frame load waits for the boundary.
    seekPhase(12);
    doLoad(16'h1234);
    checkVal("pendSet", pendingO, 1);
    seekPhase(0);
    cyc();
    checkVal("pendClr", pendingO, 0);
    seekPhase(2);
    cyc();
    checkVal("slot0Bcd", bcd, 4);
    seekPhase(26);
    cyc();
    checkVal("slot3Bcd", bcd, 1);

    // Last load wins; leading-zero blanking.
    blankLz = 1'b1;
    seekPhase(5);
    doLoad(16'h1111);
    idle(3);
    doLoad(16'h0042);
    seekPhase(0);
    cyc();
    seekPhase(10);
    cyc();
    checkVal("lzSlot1Bcd", bcd, 4);
    checkVal("lzSlot1Blank", decBlank, 0);
    seekPhase(18);
    cyc();
    checkVal("lzSlot2Blank", decBlank, 1);
    seekPhase(26);
    cyc();
    checkVal("lzSlot3Blank", decBlank, 1);
    doLoad(16'h0000);
    seekPhase(2);
    cyc();
    checkVal("zeroSlot0Blank", decBlank, 0);
    seekPhase(10);
    cyc();
    checkVal("zeroSlot1Blank", decBlank, 1);

    // Invalid BCD digit is blanked regardless of blank_lz.
    blankLz = 1'b0;
    doLoad(16'h00A5);
    seekPhase(10);
    cyc();
    checkVal("hexBcd", bcd, 4'hA);
    checkVal("hexBlank", decBlank, 1);

    // Load exactly on the boundary cycle.
    seekPhase(0);
    doLoad(16'h5678);
    checkVal("bndFs", frameStart, 1);
    checkVal("bndPend", pendingO, 0);
    seekPhase(2);
    cyc();
    checkVal("bndBcd", bcd, 8);

    // Reset mid-drive with a load pending.
    seekPhase(17);
    doLoad(16'h9999);
    seekPhase(20);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checkVal("midRstAn", an, 4'hF);
    checkVal("midRstBlank", decBlank, 1);
    checkVal("midRstPend", pendingO, 0);
    idle(3);
    checkVal("postRstBcd", bcd, 0);
    idle(40);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        for (int j = 0; j < 4; j++)
          d[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        load     = 1'b1;
        digitsIn = d;
      end
      if ($urandom_range(0, 39) == 0) blankLz = ~blankLz;
      rst = ($urandom_range(0, 399) == 0);
      cyc();
      load = 1'b0;
      rst  = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire
